// File: rtl/mic_frame_buffer.sv
// Ping-pong frame buffer: fills one bank from the microphone packer while the other streams to the FFT.
// Optional build macro MIC_FRAME_DC_REMOVE_EN subtracts the 7-bit midscale (64) from the stored real part.
module mic_frame_buffer #(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = 256
) (
    input  logic             adc_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overrun
);

    localparam int            AW        = $clog2(FRAME_LEN);
    localparam int            HALF      = WIDTH / 2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

    rd_state_t        state, state_next;
    logic [WIDTH-1:0] mem [2*FRAME_LEN];
    logic [1:0]       full, full_next;
    logic             wr_bank, rd_bank;
    logic [AW-1:0]    wr_addr, rd_addr, rd_addr_next;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en, wr_done, handshake, release_bank;

    assign wr_en        = sample_valid && !full[wr_bank];
    assign wr_done      = wr_en && (wr_addr == LAST_ADDR);
    assign handshake    = (state == STREAM) && out_valid && out_ready;
    assign release_bank = handshake && out_last;
    assign rd_addr_next = rd_addr + 1'b1;

    always_comb begin
`ifdef MIC_FRAME_DC_REMOVE_EN
        wr_data = {sample_in[WIDTH-1:HALF], sample_in[HALF-1:0] - HALF'(64)};
`else
        wr_data = sample_in;
`endif
    end

    // NOTE: the sample storage has no reset; only the pointers and flags define what is valid.
    always_ff @(posedge adc_clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_addr <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (sample_valid && full[wr_bank]) overrun <= 1'b1;
        end
    end

    // Writer and reader always target different banks, so a same-cycle set and clear never collide.
    always_comb begin
        // NOTE: default first so no path through this block leaves full_next unassigned (no latch).
        full_next = full;
        if (release_bank) full_next[rd_bank] = 1'b0;
        if (wr_done)      full_next[wr_bank] = 1'b1;
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) full <= 2'b00;
        else       full <= full_next;
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (full[rd_bank]) state_next = LOAD;
            LOAD:    state_next = STREAM;
            STREAM:  if (release_bank) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // out_data always holds bank[rd_addr]; a handshake prefetches the next address so there are no bubbles.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    rd_addr   <= '0;
                    out_data  <= mem[{rd_bank, AW'(0)}];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
                STREAM: begin
                    if (handshake) begin
                        if (out_last) begin
                            rd_bank   <= ~rd_bank;
                            rd_addr   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_addr  <= rd_addr_next;
                            out_data <= mem[{rd_bank, rd_addr_next}];
                            out_last <= (rd_addr_next == LAST_ADDR);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Self-checking bench for mic_frame_buffer (FRAME_LEN=8): vector tables feed a scoreboard checked at each handshake.
// Expected data follows the MIC_FRAME_DC_REMOVE_EN build macro when it is defined.
module tb_mic_frame_buffer;

    localparam int W  = 32;
    localparam int FL = 8;

    logic          adc_clk = 1'b0;
    logic          reset;
    logic [W-1:0]  sample_in;
    logic          sample_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          overrun;

    mic_frame_buffer #(.WIDTH(W), .FRAME_LEN(FL)) dut (
        .adc_clk      (adc_clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .overrun      (overrun)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        logic [W-1:0] sample;
        logic [W-1:0] exp_plain;
        logic [W-1:0] exp_dc;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    vec_t ramp_tbl [FL];
    vec_t dc_tbl   [FL];
    exp_t sb [$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int acc_cnt  = 0;
    int ready_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: held low
    int ready_cnt  = 0;
    int hs_before;

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input vec_t v);
`ifdef MIC_FRAME_DC_REMOVE_EN
        return v.exp_dc;
`else
        return v.exp_plain;
`endif
    endfunction

    function automatic logic [W-1:0] exp_of(input logic [W-1:0] s);
`ifdef MIC_FRAME_DC_REMOVE_EN
        return {s[W-1:W/2], s[W/2-1:0] - 16'd64};
`else
        return s;
`endif
    endfunction

    // Drive one strobe for one cycle; accepted samples are queued with their expected frame position.
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] exp, input bit accept);
        exp_t x;
        sample_in    = s;
        sample_valid = 1'b1;
        if (accept) begin
            x.data = exp;
            x.last = (acc_cnt == FL - 1);
            sb.push_back(x);
            acc_cnt = (acc_cnt + 1) % FL;
        end
        @(posedge adc_clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin
            @(posedge adc_clk);
            t++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    always @(posedge adc_clk) begin
        #1;
        ready_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_cnt % 3 == 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: handshake completes on the next rising edge, so sample on the falling edge before it.
    always @(negedge adc_clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    check("extra_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("data", out_data, e.data);
                    check("last", out_last, e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < FL; i++) begin
            ramp_tbl[i].sample    = W'(i + 1);
            ramp_tbl[i].exp_plain = W'(i + 1);
            ramp_tbl[i].exp_dc    = {16'h0000, 16'(i + 1) - 16'd64};
        end
        dc_tbl[0] = '{32'h1234_0000, 32'h1234_0000, 32'h1234_FFC0};
        dc_tbl[1] = '{32'hABCD_0040, 32'hABCD_0040, 32'hABCD_0000};
        dc_tbl[2] = '{32'h00FF_007F, 32'h00FF_007F, 32'h00FF_003F};
        dc_tbl[3] = '{32'h8000_FFFF, 32'h8000_FFFF, 32'h8000_FFBF};
        dc_tbl[4] = '{32'h0001_0041, 32'h0001_0041, 32'h0001_0001};
        dc_tbl[5] = '{32'hFFFF_003F, 32'hFFFF_003F, 32'hFFFF_FFFF};
        dc_tbl[6] = '{32'h5A5A_8000, 32'h5A5A_8000, 32'h5A5A_7FC0};
        dc_tbl[7] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_00C0};

        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        idle(2);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        idle(1);

        // Ramp 1..8, always ready: latency and 8 consecutive valid cycles.
        for (int i = 0; i < FL; i++) send(ramp_tbl[i].sample, pick(ramp_tbl[i]), 1'b1);
        check("lat_write_edge", out_valid, 0);
        idle(1);
        check("lat_load", out_valid, 0);
        idle(1);
        check("lat_first", out_valid, 1);
        for (int i = 1; i < FL; i++) begin
            idle(1);
            check("burst_valid", out_valid, 1);
        end
        idle(1);
        check("burst_end", out_valid, 0);
        check("ramp_overrun", overrun, 0);

        // Same ramp under a 1,0,0 ready pattern.
        ready_mode = 1;
        hs_before  = hs_count;
        for (int i = 0; i < FL; i++) send(ramp_tbl[i].sample, pick(ramp_tbl[i]), 1'b1);
        drain();
        check("stall_handshakes", hs_count - hs_before, FL);
        ready_mode = 0;
        idle(2);

        // Midscale-removal corner values.
        for (int i = 0; i < FL; i++) send(dc_tbl[i].sample, pick(dc_tbl[i]), 1'b1);
        drain();

        // Five frames; the reader spends IDLE+LOAD between frames, so leave a 2-cycle gap per frame.
        hs_before = hs_count;
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < FL; i++) send(W'(1000 + f * FL + i), exp_of(W'(1000 + f * FL + i)), 1'b1);
            idle(2);
        end
        drain();
        check("five_frame_handshakes", hs_count - hs_before, 5 * FL);
        check("five_frame_overrun", overrun, 0);

        // Both banks fill with the consumer stalled; samples 17..24 are dropped.
        ready_mode = 2;
        idle(1);
        hs_before = hs_count;
        for (int i = 1; i <= 16; i++) send(W'(i), exp_of(W'(i)), 1'b1);
        check("overrun_before_drop", overrun, 0);
        for (int i = 17; i <= 24; i++) send(W'(i), exp_of(W'(i)), 1'b0);
        check("overrun_after_drop", overrun, 1);
        check("stalled_valid", out_valid, 1);
        ready_mode = 0;
        drain();
        check("overflow_handshakes", hs_count - hs_before, 2 * FL);
        idle(20);
        check("no_extra_frames", hs_count - hs_before, 2 * FL);

        // Reset during sample 5 of the next frame while the previous one streams.
        for (int i = 0; i < FL; i++) send(W'(300 + i), exp_of(W'(300 + i)), 1'b1);
        for (int i = 0; i < 4; i++) send(W'(400 + i), exp_of(W'(400 + i)), 1'b1);
        sample_in    = W'(404);
        sample_valid = 1'b1;
        check("pre_reset_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_overrun", overrun, 0);
        sample_valid = 1'b0;
        sb.delete();
        acc_cnt = 0;
        idle(2);
        reset = 1'b0;
        idle(1);
        hs_before = hs_count;
        for (int i = 0; i < FL; i++) send(W'(500 + i), exp_of(W'(500 + i)), 1'b1);
        drain();
        idle(12);
        check("post_reset_handshakes", hs_count - hs_before, FL);
        check("post_reset_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
